// File: rtl/seq_divider_16.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, MSB first.
// Define DIVIDER_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module seq_divider_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int                CW        = $clog2(WIDTH);
  localparam int unsigned       LAST_I    = WIDTH - 32'd1;
  localparam logic [CW-1:0]     CNT_LAST  = CW'(LAST_I);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0]     CNT_ZERO  = {CW{1'b0}};
  localparam logic [WIDTH-1:0]  ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  ONES_W    = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]    ZERO_R    = {(WIDTH+1){1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;

  logic [WIDTH:0]     r_shift_s;
  logic               ge_s;
  logic [WIDTH:0]     r_next_s;
  logic [WIDTH-1:0]   q_next_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH-1:0]   quo_fin_s;
  logic [WIDTH-1:0]   rem_fin_s;
  logic               accept_s;

  assign accept_s = in_valid & in_ready_q;

  // rem_q[WIDTH] acts as the carry of the shift, so it forces a subtract.
  assign r_shift_s = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign ge_s      = rem_q[WIDTH] | (r_shift_s >= {1'b0, div_q});
  assign r_next_s  = ge_s ? (r_shift_s - {1'b0, div_q}) : r_shift_s;
  assign q_next_s  = {quo_q[WIDTH-2:0], ge_s};

`ifdef DIVIDER_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign a_mag_s   = dividend[WIDTH-1] ? neg2(dividend) : dividend;
  assign b_mag_s   = divisor[WIDTH-1]  ? neg2(divisor)  : divisor;
  assign quo_fin_s = neg_quo_q ? neg2(q_next_s) : q_next_s;
  assign rem_fin_s = neg_rem_q ? neg2(r_next_s[WIDTH-1:0]) : r_next_s[WIDTH-1:0];

  // Sign flags for the fix-up applied on entry to DONE.
  always_comb begin
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (accept_s) begin
      neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_rem_d = dividend[WIDTH-1];
    end else begin
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
    end
  end

  // Sign flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  assign a_mag_s   = dividend;
  assign b_mag_s   = divisor;
  assign quo_fin_s = q_next_s;
  assign rem_fin_s = r_next_s[WIDTH-1:0];
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (divisor == ZERO_W) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            quotient_d  = ONES_W;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_ZERO;
            rem_d   = ZERO_R;
            quo_d   = a_mag_s;
            div_d   = b_mag_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = r_next_s;
        quo_d = q_next_s;
        if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          cnt_d       = CNT_ZERO;
          out_valid_d = 1'b1;
          quotient_d  = quo_fin_s;
          remainder_d = rem_fin_s;
          dbz_d       = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      rem_q       <= ZERO_R;
      quo_q       <= ZERO_W;
      div_q       <= ZERO_W;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= ZERO_W;
      remainder_q <= ZERO_W;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;

endmodule
